// File: rtl/add_sub_serial_pkg.sv
// add_sub_serial_pkg: shared state encodings and default keys for the bit-serial add/sub pair
package add_sub_serial_pkg;
  localparam int WIDTH_DEF = 8;
  localparam logic [7:0] MASK_A_DEF = 8'h5B;
  localparam logic [7:0] MASK_B_DEF = 8'h15;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;
endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: combinational 1-bit full subtractor
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/sub_serial.sv
// sub_serial: LSB-first bit-serial subtractor with descrambled operands and a dummy wait state
module sub_serial
  import add_sub_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] MASK_A = WIDTH'(MASK_A_DEF),
  parameter logic [WIDTH-1:0] MASK_B = WIDTH'(MASK_B_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [CW-1:0] count_q, count_d;
  logic borrow_q, borrow_d, d_bit, bout_bit;
  full_sub_cell u_cell (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (borrow_q),
    .d   (d_bit),
    .bout(bout_bit)
  );
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    if (state_q == IDLE && en) begin
      a_d      = a ^ MASK_A;
      b_d      = b ^ MASK_B;
      out_d    = '0;
      borrow_d = 1'b0;
      count_d  = '0;
      state_d  = WAIT;
    end else if (state_q == WAIT) begin
      state_d = SUB;
    end else if (state_q == SUB) begin
      out_d    = {d_bit, out_q[WIDTH-1:1]};
      borrow_d = bout_bit;
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      count_d  = (count_q == LAST) ? '0 : count_q + 1'b1;
      state_d  = (count_q == LAST) ? DONE : SUB;
    end else if (state_q == DONE && en) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
    end
  end
  assign out        = out_q;
  assign done       = (state_q == DONE);
  assign borrow_out = done & borrow_q;
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed self-checking bench for sub_serial
module tb_sub_serial;
  logic clk = 1'b0;
  logic rst, en, borrow_out, done;
  logic [7:0] a, b, out, hold_out;
  int checks = 0;
  int errors = 0;
  sub_serial dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .a         (a),
    .b         (b),
    .out       (out),
    .borrow_out(borrow_out),
    .done      (done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic finish_run(input string tag, input logic [7:0] eo, input logic eb);
    repeat (8) step();
    chk({tag, "_done_early"}, done, 0);
    chk({tag, "_borrow_hidden"}, borrow_out, 0);
    step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_borrow"}, borrow_out, eb);
  endtask
  task automatic run(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                     input logic [7:0] eo, input logic eb);
    a = ai;
    b = bi;
    en = 1;
    step();
    en = 0;
    finish_run(tag, eo, eb);
  endtask
  task automatic release_done();
    en = 1;
    step();
    chk("release_idle", done, 0);
    en = 0;
    step();
  endtask
  initial begin
    rst = 1;
    en = 0;
    a = 0;
    b = 0;
    repeat (2) step();
    chk("rst_out", out, 0);
    chk("rst_done", done, 0);
    chk("rst_borrow", borrow_out, 0);
    rst = 0;
    step();
    run("basic", 8'h4B, 8'h16, 8'h0D, 0);
    release_done();
    chk("idle_hold_out", out, 8'h0D);
    run("under", 8'h58, 8'h05, 8'hF3, 1);
    release_done();
    run("zero", 8'h5B, 8'h15, 8'h00, 0);
    release_done();
    run("extreme", 8'h5B, 8'hEA, 8'h01, 1);
    release_done();
    a = 8'h4B;
    b = 8'h16;
    en = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      en = ~en;
      a = 8'($urandom);
      b = 8'($urandom);
      step();
    end
    en = 0;
    chk("ign_done_early", done, 0);
    step();
    chk("ign_done", done, 1);
    chk("ign_out", out, 8'h0D);
    chk("ign_borrow", borrow_out, 0);
    release_done();
    a = 8'h58;
    b = 8'h05;
    en = 1;
    step();
    en = 0;
    repeat (4) step();
    #2 rst = 1;
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_borrow", borrow_out, 0);
    step();
    #2 rst = 0;
    step();
    chk("post_rst_idle", done, 0);
    run("fresh", 8'h58, 8'h05, 8'hF3, 1);
    hold_out = out;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hs_done", done, 1);
      chk("hs_out", out, hold_out);
      chk("hs_borrow", borrow_out, 1);
    end
    a = 8'h5B;
    b = 8'hEA;
    en = 1;
    step();
    chk("hs_idle_done", done, 0);
    chk("hs_idle_out", out, 8'hF3);
    step();
    en = 0;
    chk("hs_load_out", out, 0);
    chk("hs_load_done", done, 0);
    finish_run("hs_run", 8'h01, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
